// File: rtl/cache_mem_responder.sv
// Memory-side responder for cache refills, word reads, writebacks and strobed writes.
// Define CACHE_MEM_RAND_STALL_EN to add LFSR-driven stall cycles to reads and writes.
module cache_mem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int RD_LATENCY = 2,
  parameter int WR_LATENCY = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy
);
  // state   | meaning
  // IDLE    | ready for a request
  // RD_WAIT | read latency countdown
  // RD_DATA | return beats; ret_valid low here marks a gap before the next beat
  // WR_BUSY | write latency countdown, commit when the counter reaches zero

  localparam int MAX_LAT = ((RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY) + 3;
  localparam int CW = $clog2(MAX_LAT + 1);
  localparam logic [2:0] TYPE_LINE = 3'b100;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DATA, WR_BUSY} state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [ADDR_WIDTH-1:0] rd_idx, rd_idx_n;
  logic [1:0]            rem, rem_n;
  logic                  ret_valid_n, ret_last_n;
  logic [31:0]           ret_data_n;
  logic [ADDR_WIDTH-1:0] wr_idx, wr_idx_n;
  logic                  wr_line, wr_line_n;
  logic [3:0]            wr_strb, wr_strb_n;
  logic [127:0]          wr_buf, wr_buf_n;
  logic                  commit, emit;
  logic [CW-1:0]         rd_wait, wr_wait;
  logic                  gap;
  logic [31:0]           mem [2**ADDR_WIDTH];

`ifdef CACHE_MEM_RAND_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (!resetn) lfsr <= 16'hACE1;
    else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign rd_wait = CW'(RD_LATENCY) + CW'(lfsr[1:0]);
  assign wr_wait = CW'(WR_LATENCY) + CW'(lfsr[3:2]);
  assign gap     = lfsr[4];
`else
  assign rd_wait = CW'(RD_LATENCY);
  assign wr_wait = CW'(WR_LATENCY);
  assign gap     = 1'b0;
`endif

  // Address bits outside the array window alias; byte offset is irrelevant to word access.
  logic unused_bits;
  assign unused_bits = ^{rd_addr[31:ADDR_WIDTH+2], rd_addr[1:0],
                         wr_addr[31:ADDR_WIDTH+2], wr_addr[1:0]};

  assign wr_rdy = (state == IDLE);
  assign rd_rdy = (state == IDLE) & ~wr_req;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    rd_idx_n    = rd_idx;
    rem_n       = rem;
    ret_valid_n = 1'b0;
    ret_last_n  = 1'b0;
    ret_data_n  = ret_data;
    wr_idx_n    = wr_idx;
    wr_line_n   = wr_line;
    wr_strb_n   = wr_strb;
    wr_buf_n    = wr_buf;
    commit      = 1'b0;
    emit        = 1'b0;

    case (state)
      IDLE: begin
        if (wr_req) begin
          wr_line_n = (wr_type == TYPE_LINE);
          wr_idx_n  = (wr_type == TYPE_LINE) ? {wr_addr[ADDR_WIDTH+1:4], 2'b00}
                                             : wr_addr[ADDR_WIDTH+1:2];
          wr_strb_n = wr_wstrb;
          wr_buf_n  = wr_data;
          cnt_n     = wr_wait;
          state_n   = WR_BUSY;
        end else if (rd_req) begin
          rd_idx_n = (rd_type == TYPE_LINE) ? {rd_addr[ADDR_WIDTH+1:4], 2'b00}
                                            : rd_addr[ADDR_WIDTH+1:2];
          rem_n    = (rd_type == TYPE_LINE) ? 2'd3 : 2'd0;
          if (rd_wait == '0) begin
            state_n = RD_DATA;
            emit    = 1'b1;
          end else begin
            state_n = RD_WAIT;
            cnt_n   = rd_wait - CW'(1);
          end
        end
      end
      RD_WAIT: begin
        if (cnt == '0) begin
          state_n = RD_DATA;
          emit    = 1'b1;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      RD_DATA: begin
        if (!ret_valid)    emit    = 1'b1;
        else if (ret_last) state_n = IDLE;
        else if (!gap)     emit    = 1'b1;
      end
      WR_BUSY: begin
        if (cnt == '0) begin
          commit  = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // Beat data is registered so ret_data holds between beats and after the read.
    if (emit) begin
      ret_valid_n = 1'b1;
      ret_data_n  = mem[rd_idx_n];
      ret_last_n  = (rem_n == 2'd0);
      rd_idx_n    = rd_idx_n + ADDR_WIDTH'(1);
      rem_n       = rem_n - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_idx    <= '0;
      rem       <= '0;
      ret_valid <= 1'b0;
      ret_last  <= 1'b0;
      ret_data  <= '0;
      wr_idx    <= '0;
      wr_line   <= 1'b0;
      wr_strb   <= '0;
      wr_buf    <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rd_idx    <= rd_idx_n;
      rem       <= rem_n;
      ret_valid <= ret_valid_n;
      ret_last  <= ret_last_n;
      ret_data  <= ret_data_n;
      wr_idx    <= wr_idx_n;
      wr_line   <= wr_line_n;
      wr_strb   <= wr_strb_n;
      wr_buf    <= wr_buf_n;
    end
  end

  // Backing array has no reset; a write caught by reset before commit is dropped.
  always_ff @(posedge clk) begin
    if (resetn && commit) begin
      if (wr_line) begin
        for (int k = 0; k < 4; k++)
          mem[{wr_idx[ADDR_WIDTH-1:2], 2'(k)}] <= wr_buf[32*k +: 32];
      end else begin
        for (int b = 0; b < 4; b++)
          if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_buf[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed self-checking bench for cache_mem_responder (default parameters).
// With CACHE_MEM_RAND_STALL_EN defined, exact-timing checks are skipped and random line reads are added.
module tb_cache_mem_responder;
  logic         clk = 1'b0;
  logic         resetn;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic         ret_last;
  logic [31:0]  ret_data;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;

  int checks = 0;
  int errors = 0;

  logic [31:0] beats [4];
  int nbeats, nlast, last_pos, first_c, rdy_back, rd_stall, busy, wait_c, extra;

  cache_mem_responder dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a write from IDLE and count the cycles wr_rdy stays low.
  task automatic do_write(input logic [2:0] t, input logic [31:0] a,
                          input logic [3:0] s, input logic [127:0] d);
    wr_type  = t;
    wr_addr  = a;
    wr_wstrb = s;
    wr_data  = d;
    wr_req   = 1'b1;
    tick();
    wr_req = 1'b0;
    busy   = 0;
    while (!wr_rdy && busy < 50) begin
      busy++;
      tick();
    end
  endtask

  // Issue a read, then capture beats with their cycle offsets from acceptance.
  task automatic do_read(input logic [2:0] t, input logic [31:0] a);
    rd_type = t;
    rd_addr = a;
    rd_req  = 1'b1;
    #1;
    rd_stall = 0;
    while (!rd_rdy && rd_stall < 50) begin
      rd_stall++;
      tick();
    end
    tick();
    rd_req   = 1'b0;
    nbeats   = 0;
    nlast    = 0;
    last_pos = -1;
    first_c  = -1;
    rdy_back = -1;
    for (int c = 1; c <= 24; c++) begin
      if (ret_valid) begin
        if (nbeats < 4) beats[nbeats] = ret_data;
        if (first_c < 0) first_c = c;
        if (ret_last) begin
          nlast++;
          last_pos = nbeats;
        end
        nbeats++;
      end
      if (rdy_back < 0 && rd_rdy) rdy_back = c;
      tick();
    end
  endtask

`ifdef CACHE_MEM_RAND_STALL_EN
  logic [127:0] ref_line [16];
`endif

  initial begin
    resetn   = 1'b0;
    rd_req   = 1'b0;
    rd_type  = 3'b000;
    rd_addr  = '0;
    wr_req   = 1'b0;
    wr_type  = 3'b000;
    wr_addr  = '0;
    wr_wstrb = '0;
    wr_data  = '0;
    tick();
    tick();
    check("rst_ret_valid", 32'(ret_valid), 32'd0);
    check("rst_ret_last",  32'(ret_last),  32'd0);
    check("rst_ret_data",  ret_data,       32'h0);
    check("rst_rd_rdy",    32'(rd_rdy),    32'd1);
    check("rst_wr_rdy",    32'(wr_rdy),    32'd1);
    resetn = 1'b1;
    tick();

    // Line read of 0x108 returns the whole line starting at 0x100
    do_write(3'b100, 32'h100, 4'h0,
             {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
`ifndef CACHE_MEM_RAND_STALL_EN
    check("preload_busy", 32'(busy), 32'd3);
`endif
    do_read(3'b100, 32'h108);
    check("line_nbeats", 32'(nbeats), 32'd4);
    check("line_beat0", beats[0], 32'h11111111);
    check("line_beat1", beats[1], 32'h22222222);
    check("line_beat2", beats[2], 32'h33333333);
    check("line_beat3", beats[3], 32'h44444444);
    check("line_nlast", 32'(nlast), 32'd1);
    check("line_last_pos", 32'(last_pos), 32'd3);
    check("line_data_hold", ret_data, 32'h44444444);
`ifndef CACHE_MEM_RAND_STALL_EN
    check("line_first_cycle", 32'(first_c), 32'd3);
    check("line_rdy_back", 32'(rdy_back), 32'd7);
`endif

    // Strobed word write over an old value
    do_write(3'b010, 32'h204, 4'hF, {96'h0, 32'h12345678});
    do_write(3'b010, 32'h204, 4'b0101, {96'h0, 32'hAABBCCDD});
    do_read(3'b010, 32'h204);
    check("strb_nbeats", 32'(nbeats), 32'd1);
    check("strb_data", beats[0], 32'h12BB56DD);
    check("strb_nlast", 32'(nlast), 32'd1);
`ifndef CACHE_MEM_RAND_STALL_EN
    check("word_first_cycle", 32'(first_c), 32'd3);
    check("word_rdy_back", 32'(rdy_back), 32'd4);
`endif

    // Byte-typed write still obeys wr_wstrb only; sub-word reads return the full word
    do_write(3'b000, 32'h206, 4'b1000, {96'h0, 32'h99000000});
    do_read(3'b001, 32'h206);
    check("half_read_full_word", beats[0], 32'h99BB56DD);
    do_read(3'b000, 32'h207);
    check("byte_read_full_word", beats[0], 32'h99BB56DD);
    do_read(3'b011, 32'h204);
    check("unknown_type_nbeats", 32'(nbeats), 32'd1);
    check("unknown_type_data", beats[0], 32'h99BB56DD);

    // Address bits above the array window alias
    do_read(3'b010, 32'h4100);
    check("alias_data", beats[0], 32'h11111111);

    // Line writeback then immediate refill
    do_write(3'b100, 32'h300, 4'h0, {32'hD, 32'hC, 32'hB, 32'hA});
`ifndef CACHE_MEM_RAND_STALL_EN
    check("wb_busy", 32'(busy), 32'd3);
`endif
    do_read(3'b100, 32'h300);
    check("refill_beat0", beats[0], 32'hA);
    check("refill_beat1", beats[1], 32'hB);
    check("refill_beat2", beats[2], 32'hC);
    check("refill_beat3", beats[3], 32'hD);
    check("refill_nlast", 32'(nlast), 32'd1);

    // Simultaneous read and write to 0x400: write wins
    do_write(3'b010, 32'h400, 4'hF, {96'h0, 32'h01010101});
    rd_type  = 3'b010;
    rd_addr  = 32'h400;
    rd_req   = 1'b1;
    wr_type  = 3'b010;
    wr_addr  = 32'h400;
    wr_wstrb = 4'hF;
    wr_data  = {96'h0, 32'hCAFEBABE};
    wr_req   = 1'b1;
    #1;
    check("sim_rd_rdy", 32'(rd_rdy), 32'd0);
    check("sim_wr_rdy", 32'(wr_rdy), 32'd1);
    tick();
    wr_req = 1'b0;
    do_read(3'b010, 32'h400);
`ifndef CACHE_MEM_RAND_STALL_EN
    check("sim_rd_stall", 32'(rd_stall), 32'd3);
`endif
    check("sim_read_new", beats[0], 32'hCAFEBABE);

    // Reset during a line read
    rd_type = 3'b100;
    rd_addr = 32'h100;
    rd_req  = 1'b1;
    tick();
    rd_req = 1'b0;
    wait_c = 0;
    while (!ret_valid && wait_c < 20) begin
      wait_c++;
      tick();
    end
    check("midrst_beat0", ret_data, 32'h11111111);
    resetn = 1'b0;
    tick();
    check("midrst_ret_valid", 32'(ret_valid), 32'd0);
    check("midrst_ret_last",  32'(ret_last),  32'd0);
    check("midrst_ret_data",  ret_data,       32'h0);
    check("midrst_rd_rdy",    32'(rd_rdy),    32'd1);
    check("midrst_wr_rdy",    32'(wr_rdy),    32'd1);
    resetn = 1'b1;
    extra  = 0;
    for (int c = 0; c < 10; c++) begin
      if (ret_valid) extra++;
      tick();
    end
    check("midrst_no_more_beats", 32'(extra), 32'd0);

`ifdef CACHE_MEM_RAND_STALL_EN
    for (int l = 0; l < 16; l++) begin
      ref_line[l] = {$urandom, $urandom, $urandom, $urandom};
      do_write(3'b100, 32'h1000 + 32'(l * 16), 4'h0, ref_line[l]);
    end
    for (int i = 0; i < 100; i++) begin
      int l;
      l = int'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        ref_line[l] = {$urandom, $urandom, $urandom, $urandom};
        do_write(3'b100, 32'h1000 + 32'(l * 16), 4'h0, ref_line[l]);
      end
      do_read(3'b100, 32'h1000 + 32'(l * 16) + 32'($urandom_range(0, 15)));
      check("rand_nbeats", 32'(nbeats), 32'd4);
      check("rand_nlast", 32'(nlast), 32'd1);
      check("rand_last_pos", 32'(last_pos), 32'd3);
      for (int k = 0; k < 4; k++)
        check("rand_beat", beats[k], ref_line[l][32*k +: 32]);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
